// File: rtl/cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter
//
// Shares one iterative CORDIC cosine core between NUM_REQ requesters. A
// round-robin arbiter picks one requester at a time and latches its FP angle.
// It gives the core one start/clock-enable cycle, then clocks the core until
// it reports done and never past it. The FP cosine goes back as a single-cycle
// response tagged with the requester's ID.
//
// Optional feature: define CORDIC_ARB_WATCHDOG_EN to enable a RUN-state
// watchdog. A stuck core is then abandoned with rsp_err=1 and rsp_data=0, and
// the response lands TIMEOUT+3 cycles after ack. Without the macro, rsp_err is
// tied 0 and RUN waits for core_done indefinitely.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   ID_W     requester ID width, clog2(NUM_REQ)
//   TIMEOUT  watchdog limit (watchdog build only)
//
// Ports
//   clock        rising-edge clock
//   aclr         asynchronous active-high reset (also drives the core's aclr)
//   req          level request per requester, held until ack
//   req_data     FP angle of requester i at [32i+31:32i]
//   ack          one-hot, one-cycle pulse: request accepted, angle latched
//   rsp_valid    one-cycle pulse: result available
//   rsp_id       requester that owns rsp_data
//   rsp_data     FP cosine result
//   rsp_err      result aborted by watchdog (qualified by rsp_valid)
//   busy         high in every state except IDLE
//   core_start   core start strobe
//   core_clk_en  core clock enable
//   core_dataa   latched angle presented to the core
//   core_result  core result
//   core_done    core finished (iteration index reached 16)
// -----------------------------------------------------------------------------
module cordic_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                    clock,
  input  logic                    aclr,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    core_start,
  output logic                    core_clk_en,
  output logic [31:0]             core_dataa,
  input  logic [31:0]             core_result,
  input  logic                    core_done
);

  // Reject configurations the arbitration arithmetic does not support. A
  // normal operation needs 17 RUN cycles, so the watchdog must allow at least that.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT < 16) begin : g_cfg_check
    $error("cordic_share_arbiter: unsupported NUM_REQ/ID_W/TIMEOUT combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t          state, next_state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            wd_expire;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first requester at or after ptr, wrapping. ptr is
  // set to last-served+1, so the most recently served requester is lowest.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W:0] cand;
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_valid && req[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog. The counter clears in LOAD and counts RUN cycles. The
  // abort fires on the (TIMEOUT+2)-th RUN cycle, so RESP comes TIMEOUT+3 cycles
  // after the ack cycle.
  // ---------------------------------------------------------------------------
`ifdef CORDIC_ARB_WATCHDOG_EN
  localparam int               WD_W     = $clog2(TIMEOUT + 2);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            rsp_err_q;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wd_cnt <= '0;
    end else if (state == S_LOAD) begin
      wd_cnt <= '0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // A real result wins if done and expiry coincide.
  assign wd_expire = (state == S_RUN) && !core_done && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rsp_err_q <= 1'b0;
    end else if (state == S_RUN) begin
      if (core_done)      rsp_err_q <= 1'b0;
      else if (wd_expire) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_valid & rsp_err_q;
`else
  assign wd_expire = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge aclr) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (aclr) state <= S_IDLE;
    else      state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    core_start  = 1'b0;
    core_clk_en = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_valid) next_state = S_LOAD;
      end
      S_LOAD: begin
        core_start  = 1'b1;
        core_clk_en = 1'b1;
        next_state  = S_RUN;
      end
      S_RUN: begin
        // Gate the clock combinationally so the core freezes in the same
        // cycle it reports done (or the watchdog gives up).
        core_clk_en = !core_done && !wd_expire;
        if (core_done || wd_expire) next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign rsp_id = rsp_valid ? cur_id : '0;

  // ---------------------------------------------------------------------------
  // Datapath: grant latch, ack pulse, result capture, pointer rotation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ack        <= '0;
      cur_id     <= '0;
      core_dataa <= '0;
      rsp_data   <= '0;
      ptr        <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_valid) begin
            ack        <= NUM_REQ'(1) << grant_id;
            cur_id     <= grant_id;
            core_dataa <= req_data[32*grant_id +: 32];
          end
        end
        S_RUN: begin
          if (core_done)      rsp_data <= core_result;
          else if (wd_expire) rsp_data <= '0;
        end
        S_RESP: begin
          ptr <= (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_share_arbiter
//
// Directed bench for cordic_share_arbiter with a behavioural stand-in for the
// iterative CORDIC core. The stand-in latches the angle on start and advances
// one iteration per enabled clock. It raises done at iteration 16 and returns
// a fixed, easily predicted function of the angle, so 0.0 maps to 1.0. Expected
// responses go into a scoreboard queue when a request is driven. A monitor pops
// and compares them whenever rsp_valid fires.
// -----------------------------------------------------------------------------
module tb_cordic_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 32;

  logic                  clock;
  logic                  aclr;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  core_start;
  logic                  core_clk_en;
  logic [31:0]           core_dataa;
  logic [31:0]           core_result;
  logic                  core_done;

  logic [31:0] ang [NUM_REQ];
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = ang[i];
  end

  cordic_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .aclr        (aclr),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .core_start  (core_start),
    .core_clk_en (core_clk_en),
    .core_dataa  (core_dataa),
    .core_result (core_result),
    .core_done   (core_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Core stand-in.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] cos_mock(input logic [31:0] a);
    return a ^ 32'h3F80_0000;
  endfunction

  logic [4:0]  iter;
  logic [31:0] core_res_q;
  logic        stall;

  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      iter       <= 5'd0;
      core_res_q <= '0;
    end else if (core_clk_en && core_start) begin
      iter       <= 5'd0;
      core_res_q <= cos_mock(core_dataa);
    end else if (core_clk_en && iter != 5'd16) begin
      iter <= iter + 5'd1;
    end
  end

  assign core_done   = (iter == 5'd16) && !stall;
  assign core_result = core_res_q;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard.
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  int ack1_cnt    = 0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!aclr) begin
      check("core_clk_past_done", 32'(core_clk_en & core_done & ~core_start), 32'd0);
      if (ack[1]) ack1_cnt++;
      if (rsp_valid) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id",   32'(rsp_id),  32'(e.id));
          check("rsp_data", rsp_data,     e.data);
          check("rsp_err",  32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rsp_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("rsp_within_budget", 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ack"},         32'(ack),         32'd0);
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, "_rsp_id"},      32'(rsp_id),      32'd0);
    check({tag, "_rsp_data"},    rsp_data,         32'd0);
    check({tag, "_rsp_err"},     32'(rsp_err),     32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_core_start"},  32'(core_start),  32'd0);
    check({tag, "_core_clk_en"}, 32'(core_clk_en), 32'd0);
    check({tag, "_core_dataa"},  core_dataa,       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence.
  // ---------------------------------------------------------------------------
  initial begin
    int t0, at, prev, a_cyc, ack1_snap;

    aclr  = 1'b1;
    req   = '0;
    stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) ang[i] = '0;
    #1;
    check_cleared("reset");
    tick();
    tick();
    aclr = 1'b0;
    tick();

    // 1: single request for angle 0.0, full cycle-accurate walk.
    req    = 4'b0001;
    ang[0] = 32'h0000_0000;
    check("t1_idle_busy", 32'(busy), 32'd0);
    push(0, 32'h3F80_0000, 1'b0);
    tick();                                           // T+1
    check("t1_ack",        32'(ack),         32'b0001);
    check("t1_busy",       32'(busy),        32'd1);
    check("t1_core_start", 32'(core_start),  32'd1);
    check("t1_clk_en",     32'(core_clk_en), 32'd1);
    req = '0;
    tick();                                           // T+2
    check("t1_ack_pulse",  32'(ack),         32'd0);
    check("t1_start_once", 32'(core_start),  32'd0);
    check("t1_run_clk_en", 32'(core_clk_en), 32'd1);
    repeat (15) tick();                               // T+17
    check("t1_last_iter_en", 32'(core_clk_en), 32'd1);
    tick();                                           // T+18
    check("t1_done",        32'(core_done),   32'd1);
    check("t1_frozen",      32'(core_clk_en), 32'd0);
    check("t1_no_rsp_yet",  32'(rsp_valid),   32'd0);
    tick();                                           // T+19
    check("t1_rsp_valid",   32'(rsp_valid),   32'd1);
    check("t1_rsp_data",    rsp_data,         32'h3F80_0000);
    tick();                                           // T+20
    check("t1_busy_fall",   32'(busy),        32'd0);
    check("t1_rsp_pulse",   32'(rsp_valid),   32'd0);

    // 2: all four held from reset -> 0,1,2,3,0 spaced 20 cycles.
    aclr   = 1'b1;
    req    = 4'b1111;
    ang[0] = 32'h3E80_0000;
    ang[1] = 32'h3F00_0000;
    ang[2] = 32'h3F40_0000;
    ang[3] = 32'h3FC0_0000;
    tick();
    aclr = 1'b0;
    t0   = cyc;
    push(0, cos_mock(ang[0]), 1'b0);
    push(1, cos_mock(ang[1]), 1'b0);
    push(2, cos_mock(ang[2]), 1'b0);
    push(3, cos_mock(ang[3]), 1'b0);
    push(0, cos_mock(ang[0]), 1'b0);
    prev = t0;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(40, at);
      if (n == 0) check("t2_first_latency", 32'(at - t0), 32'd19);
      else        check("t2_spacing",       32'(at - prev), 32'd20);
      prev = at;
    end
    req = '0;
    tick();

    // 3: requester 2 served, then 0101 -> grant wraps to 0 before 2.
    req    = 4'b0100;
    ang[2] = 32'h4000_0000;
    push(2, cos_mock(ang[2]), 1'b0);
    tick();
    check("t3_ack2",   32'(ack),   32'b0100);
    check("t3_dataa2", core_dataa, 32'h4000_0000);
    req = '0;
    wait_rsp(40, at);
    req    = 4'b0101;
    ang[0] = 32'h3DCC_CCCD;
    push(0, cos_mock(32'h3DCC_CCCD), 1'b0);
    push(2, cos_mock(ang[2]), 1'b0);
    tick();
    tick();
    check("t3_wrap_ack0", 32'(ack),   32'b0001);
    check("t3_dataa0",    core_dataa, 32'h3DCC_CCCD);
    req = 4'b0100;
    wait_rsp(40, at);
    tick();
    tick();
    check("t3_then_ack2", 32'(ack), 32'b0100);
    req = '0;
    wait_rsp(40, at);
    tick();

    // 4: aclr mid-operation clears everything, no response; next op normal.
    req = 4'b0010;
    tick();                                           // T+1
    check("t4_ack1", 32'(ack), 32'b0010);
    req = '0;
    repeat (9) tick();                                // T+10
    aclr = 1'b1;
    #1;
    check_cleared("t4_aclr");
    tick();
    aclr   = 1'b0;
    req    = 4'b1000;
    ang[3] = 32'h3F20_0000;
    t0     = cyc;
    push(3, cos_mock(ang[3]), 1'b0);
    tick();
    check("t4_ack3", 32'(ack), 32'b1000);
    req = '0;
    wait_rsp(40, at);
    check("t4_latency", 32'(at - t0), 32'd19);
    tick();

    // 5: one-cycle req[1] pulse while busy is ignored.
    ack1_snap = ack1_cnt;
    req       = 4'b0001;
    ang[0]    = 32'h3E00_0000;
    push(0, cos_mock(ang[0]), 1'b0);
    tick();
    check("t5_ack0", 32'(ack), 32'b0001);
    req = '0;
    repeat (4) tick();
    req = 4'b0010;
    tick();
    req = '0;
    wait_rsp(40, at);
    tick();
    tick();
    check("t5_no_ack1",  32'(ack1_cnt), 32'(ack1_snap));
    check("t5_idle",     32'(busy),     32'd0);

    // 6: stuck core.
    stall  = 1'b1;
    req    = 4'b0010;
    ang[1] = 32'h3F10_0000;
    tick();
    check("t6_ack1", 32'(ack), 32'b0010);
    a_cyc = cyc;
    req   = '0;
`ifdef CORDIC_ARB_WATCHDOG_EN
    push(1, 32'h0000_0000, 1'b1);
    wait_rsp(TIMEOUT + 10, at);
    check("t6_abort_latency", 32'(at - a_cyc), 32'(TIMEOUT + 3));
    check("t6_abort_err",     32'(rsp_err),    32'd1);
    tick();
    stall = 1'b0;
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid) break;
    end
    check("t6_still_busy",   32'(busy),        32'd1);
    check("t6_still_clk_en", 32'(core_clk_en), 32'd1);
    check("t6_no_rsp",       32'(cyc - a_cyc), 32'd60);
    aclr = 1'b1;
    tick();
    aclr  = 1'b0;
    stall = 1'b0;
`endif
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
